// File: rtl/door_lock.sv
// door_lock: four-digit keypad combination lock.
// A press is a change of the registered key to a nonzero value. Four presses
// are compared against CODE0..CODE3. A match unlocks the door; a mismatch or
// an entry timeout shows error for ERR_CYCLES cycles.
// Optional feature macro: DOOR_LOCK_LOCKOUT_EN. When it is defined, MAX_FAILS
// consecutive failures enter a LOCKOUT state for LOCKOUT_CYCLES cycles.
module door_lock #(
  parameter logic [3:0]  CODE0          = 4'b0100,
  parameter logic [3:0]  CODE1          = 4'b1101,
  parameter logic [3:0]  CODE2          = 4'b1100,
  parameter logic [3:0]  CODE3          = 4'b1110,
  parameter logic [3:0]  RELOCK_KEY     = 4'b1111,
  parameter int unsigned ERR_CYCLES     = 4,
  parameter int unsigned ENTRY_TIMEOUT  = 32,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic       locked,
  output logic       unlocked,
  output logic       error
);

  localparam int unsigned T_A = (ENTRY_TIMEOUT > ERR_CYCLES) ? ENTRY_TIMEOUT : ERR_CYCLES;
`ifdef DOOR_LOCK_LOCKOUT_EN
  localparam int unsigned T_MAX = (LOCKOUT_CYCLES > T_A) ? LOCKOUT_CYCLES : T_A;
  localparam int unsigned FW    = $clog2(MAX_FAILS + 1);
`else
  localparam int unsigned T_MAX = T_A;
`endif
  localparam int unsigned TW = $clog2(T_MAX);

`ifdef DOOR_LOCK_LOCKOUT_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_ERROR,
    S_LOCKOUT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_UNLOCKED,
    S_ERROR
  } state_t;
`endif

  state_t          state, state_n;
  logic [3:0]      key_q, key_prev;
  logic            press;
  logic [1:0]      count, count_n;
  logic [3:0]      slot   [3];
  logic [3:0]      slot_n [3];
  logic [TW-1:0]   timer, timer_n;
  logic            fail_hit;
  logic            code_ok;
`ifdef DOOR_LOCK_LOCKOUT_EN
  logic [FW-1:0]   fails, fails_n;
`endif

  // One press per change of the registered key to a nonzero value.
  assign press = (key_q != key_prev) && (key_q != '0);

  // The fourth digit is still in key_q when the sequence completes, so it is
  // compared directly instead of being stored first.
  assign code_ok = (slot[0] == CODE0) && (slot[1] == CODE1) &&
                   (slot[2] == CODE2) && (key_q == CODE3);

  // Next-state, digit storage, timer and failure bookkeeping.
  always_comb begin
    state_n  = state;
    count_n  = count;
    slot_n   = slot;
    timer_n  = timer;
    fail_hit = 1'b0;
`ifdef DOOR_LOCK_LOCKOUT_EN
    fails_n  = fails;
`endif
    unique case (state)
      S_IDLE: begin
        if (press) begin
          slot_n[0] = key_q;
          count_n   = 2'd1;
          timer_n   = '0;
          state_n   = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (press) begin
          timer_n = '0;
          if (count == 2'd3) begin
            count_n = 2'd0;
            if (code_ok) begin
              state_n = S_UNLOCKED;
`ifdef DOOR_LOCK_LOCKOUT_EN
              fails_n = '0;
`endif
            end else begin
              fail_hit = 1'b1;
            end
          end else begin
            slot_n[count] = key_q;
            count_n       = count + 2'd1;
          end
        end else if (timer == TW'(ENTRY_TIMEOUT - 1)) begin
          count_n  = 2'd0;
          fail_hit = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      S_UNLOCKED: begin
        if (press && (key_q == RELOCK_KEY)) begin
          state_n = S_IDLE;
        end
      end
      S_ERROR: begin
        if (timer == TW'(ERR_CYCLES - 1)) begin
          state_n = S_IDLE;
          timer_n = '0;
          slot_n  = '{default: '0};
        end else begin
          timer_n = timer + TW'(1);
        end
      end
`ifdef DOOR_LOCK_LOCKOUT_EN
      S_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          state_n = S_IDLE;
          timer_n = '0;
          slot_n  = '{default: '0};
          fails_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Failures from a wrong code and from a timeout share one exit path.
    if (fail_hit) begin
      timer_n = '0;
      state_n = S_ERROR;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fails_n = fails + FW'(1);
      if ((fails + FW'(1)) >= FW'(MAX_FAILS)) begin
        state_n = S_LOCKOUT;
      end
`endif
    end
  end

  // State, key capture and registered outputs; outputs decode the next state
  // so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      key_q    <= '0;
      key_prev <= '0;
      count    <= '0;
      slot     <= '{default: '0};
      timer    <= '0;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fails    <= '0;
`endif
      locked   <= 1'b1;
      unlocked <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      key_q    <= key;
      key_prev <= key_q;
      count    <= count_n;
      slot     <= slot_n;
      timer    <= timer_n;
`ifdef DOOR_LOCK_LOCKOUT_EN
      fails    <= fails_n;
      error    <= (state_n == S_ERROR) || (state_n == S_LOCKOUT);
`else
      error    <= (state_n == S_ERROR);
`endif
      locked   <= (state_n != S_UNLOCKED);
      unlocked <= (state_n == S_UNLOCKED);
    end
  end

endmodule

// File: tb/tb_door_lock.sv
// tb_door_lock: directed and randomized stimulus for door_lock, checked
// against a cycle-level behavioural model of the lock kept in the bench.
module tb_door_lock;

  localparam logic [3:0] C0 = 4'b0100;
  localparam logic [3:0] C1 = 4'b1101;
  localparam logic [3:0] C2 = 4'b1100;
  localparam logic [3:0] C3 = 4'b1110;
  localparam logic [3:0] RELOCK = 4'b1111;
  localparam int ERRC = 4;
  localparam int TMO  = 32;
  localparam int MAXF = 3;
  localparam int LOCKC = 64;

  logic       clk;
  logic       rst;
  logic [3:0] key;
  logic       locked, unlocked, error;

  int checks = 0;
  int errors = 0;

  door_lock #(
    .CODE0(C0), .CODE1(C1), .CODE2(C2), .CODE3(C3), .RELOCK_KEY(RELOCK),
    .ERR_CYCLES(ERRC), .ENTRY_TIMEOUT(TMO), .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCKC)
  ) dut (
    .clk(clk), .rst(rst), .key(key),
    .locked(locked), .unlocked(unlocked), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: keys seen on the last two edges, entered digits,
  // and remaining error/lockout time.
  logic [3:0] k1, k2;
  logic [3:0] m_dig[$];
  int  m_err, m_lock, m_quiet, m_fails;
  bit  m_unl;

  task automatic model_reset();
    k1 = '0; k2 = '0;
    m_dig.delete();
    m_err = 0; m_lock = 0; m_quiet = 0; m_fails = 0;
    m_unl = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] kin);
    bit press;
    bit failed;
    press  = (k1 != k2) && (k1 != 4'd0);
    failed = 1'b0;
    if (m_err > 0) begin
      m_err--;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_unl) begin
      if (press && k1 == RELOCK) m_unl = 1'b0;
    end else if (m_dig.size() == 0) begin
      if (press) begin
        m_dig.push_back(k1);
        m_quiet = 0;
      end
    end else begin
      if (press) begin
        m_dig.push_back(k1);
        m_quiet = 0;
        if (m_dig.size() == 4) begin
          if (m_dig[0] == C0 && m_dig[1] == C1 && m_dig[2] == C2 && m_dig[3] == C3) begin
            m_unl = 1'b1;
            m_fails = 0;
          end else begin
            failed = 1'b1;
          end
          m_dig.delete();
        end
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin
          failed = 1'b1;
          m_dig.delete();
        end
      end
    end
    if (failed) begin
      m_fails++;
`ifdef DOOR_LOCK_LOCKOUT_EN
      if (m_fails >= MAXF) m_lock = LOCKC;
      else m_err = ERRC;
`else
      m_err = ERRC;
`endif
    end
    k2 = k1;
    k1 = kin;
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".locked"},   locked,   ~m_unl);
    chk({tag, ".unlocked"}, unlocked, m_unl);
    chk({tag, ".error"},    error,    (m_err > 0) || (m_lock > 0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".locked"},   locked,   1'b1);
    chk({tag, ".unlocked"}, unlocked, 1'b0);
    chk({tag, ".error"},    error,    1'b0);
  endtask

  // Apply a key, advance one edge, update the model and compare.
  task automatic step(input logic [3:0] k, input string tag);
    key = k;
    @(posedge clk);
    model_edge(k);
    #1;
    chk_model(tag);
  endtask

  task automatic hold(input logic [3:0] k, input int n, input string tag);
    for (int i = 0; i < n; i++) step(k, tag);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input int n, input string tag);
    hold(a, n, tag); hold(b, n, tag); hold(c, n, tag); hold(d, n, tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk_reset(tag);
    key = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset({tag, ".rel"});
  endtask

  int ecnt;
  int r;
  int n;
  logic [3:0] code [4];
  logic [3:0] kr;

  initial begin
    code[0] = C0; code[1] = C1; code[2] = C2; code[3] = C3;
    rst = 1'b0;
    key = '0;
    model_reset();

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_reset("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    hold(4'd0, 5, "post_reset");

    // Correct code with a repeated hold of 1101.
    hold(C0, 5, "ok_d0");
    hold(C1, 5, "ok_d1");
    hold(C1, 5, "ok_d1_rep");
    hold(C2, 5, "ok_d2");
    step(C3, "ok_d3_e1");
    chk("ok_edge1_unlocked", unlocked, 1'b0);
    step(C3, "ok_d3_e2");
    chk("ok_edge2_unlocked", unlocked, 1'b1);
    chk("ok_edge2_locked", locked, 1'b0);
    hold(C3, 3, "ok_hold");

    // Non-relock press is ignored; relock key locks two edges later.
    hold(4'b0101, 5, "unl_other");
    chk("unl_other_unlocked", unlocked, 1'b1);
    hold(4'd0, 2, "unl_gap");
    step(RELOCK, "relock_e1");
    chk("relock_e1_locked", locked, 1'b0);
    step(RELOCK, "relock_e2");
    chk("relock_e2_locked", locked, 1'b1);
    hold(4'd0, 3, "relock_gap");

    // Wrong code: error high for exactly ERRC cycles.
    enter(C0, C1, C2, 4'b0111, 5, "bad");
    ecnt = 0;
    for (int i = 0; i < 4; i++) if (error) ecnt++;
    hold(4'd0, 10, "bad_tail");
    chk("bad_err_seen", (ecnt > 0), 1'b1);
    ecnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'd0, "bad_count");
      if (error) ecnt++;
    end
    chk("bad_err_gone", error, 1'b0);
    enter(C0, C1, C2, C3, 3, "after_bad");
    hold(C3, 2, "after_bad_hold");
    chk("after_bad_unlocked", unlocked, 1'b1);
    hold(RELOCK, 4, "after_bad_relock");
    hold(4'd0, 2, "gap");

    // Error duration measured from a fresh failure.
    hold(C0, 3, "dur_d0"); hold(C1, 3, "dur_d1"); hold(C2, 3, "dur_d2");
    ecnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b0111, "dur_d3");
      if (error) ecnt++;
    end
    checks++;
    assert (ecnt === ERRC) else begin
      errors++;
      $error("FAIL err_cycles observed=%0d expected=%0d", ecnt, ERRC);
    end

    // Entry timeout.
    hold(4'd0, 2, "tmo_gap");
    hold(C0, 2, "tmo_d0");
    ecnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(4'd0, "tmo_idle");
      if (error) ecnt++;
    end
    checks++;
    assert (ecnt === ERRC) else begin
      errors++;
      $error("FAIL tmo_err_cycles observed=%0d expected=%0d", ecnt, ERRC);
    end

    // Reset in the middle of an entry and while unlocked.
    hold(C0, 3, "mid_d0");
    hold(C1, 3, "mid_d1");
    async_reset("rst_mid_entry");
    hold(4'd0, 2, "rst_mid_after");
    enter(C0, C1, C2, C3, 3, "rst_unl");
    hold(C3, 2, "rst_unl_hold");
    chk("rst_unl_pre", unlocked, 1'b1);
    async_reset("rst_unlocked");
    hold(4'd0, 3, "rst_unl_after");

    // Three consecutive wrong codes, then a correct code during lockout.
    for (int f = 0; f < 3; f++) begin
      enter(C0, C1, C2, 4'b0111, 3, "lk_bad");
      hold(4'd0, 8, "lk_gap");
    end
`ifdef DOOR_LOCK_LOCKOUT_EN
    chk("lk_error", error, 1'b1);
`endif
    enter(C0, C1, C2, C3, 3, "lk_try");
`ifdef DOOR_LOCK_LOCKOUT_EN
    chk("lk_try_unlocked", unlocked, 1'b0);
    chk("lk_try_error", error, 1'b1);
`endif
    hold(4'd0, 70, "lk_wait");
    chk("lk_done_error", error, 1'b0);
    enter(C0, C1, C2, C3, 3, "lk_ok");
    hold(C3, 2, "lk_ok_hold");
    chk("lk_ok_unlocked", unlocked, 1'b1);
    hold(RELOCK, 3, "lk_relock");

    // Randomized stimulus.
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 11);
      n = $urandom_range(1, 6);
      if (r <= 1) begin
        hold(4'd0, n, "rnd_zero");
      end else if (r <= 5) begin
        hold(code[r - 2], n, "rnd_digit");
      end else if (r == 6) begin
        hold(RELOCK, n, "rnd_relock");
      end else if (r <= 8) begin
        kr = 4'($urandom_range(1, 15));
        hold(kr, n, "rnd_any");
      end else if (r == 9) begin
        hold(4'd0, 35, "rnd_timeout");
      end else if (r == 10) begin
        enter(C0, C1, C2, C3, n, "rnd_code");
      end else if ($urandom_range(0, 15) == 0) begin
        async_reset("rnd_reset");
      end else begin
        hold(4'd0, 1, "rnd_tick");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
